// File: rtl/motor_ctrl_pkg.sv
// Shared types and helpers for the motor speed sequencer.
// Holds the FSM state enum, level widths and level decode helpers.
package motor_ctrl_pkg;

  localparam int LEVEL_W   = 4;
  localparam int MAX_LEVEL = 8;
  localparam int PSW_W     = 3;
  localparam int CNT_W     = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RAMP_UP,
    S_RAMP_DOWN,
    S_HOLD,
    S_ESTOP,
    S_COOLDOWN
  } motor_seq_state_t;

  // Level 0 is "off"; levels 1..8 map onto driver selects 0..7.
  function automatic logic [PSW_W-1:0] level_to_psw(
    input logic [LEVEL_W-1:0] level
  );
    if (level == '0)
      return '0;
    return PSW_W'(level - LEVEL_W'(1));
  endfunction

  // Requests above the top level clamp to the top level.
  function automatic logic [LEVEL_W-1:0] sat_level(
    input logic [LEVEL_W-1:0] speed
  );
    if (speed > LEVEL_W'(MAX_LEVEL))
      return LEVEL_W'(MAX_LEVEL);
    return speed;
  endfunction

endpackage

// File: rtl/period_tick_counter.sv
// Counts PWM period ticks and flags the tick that completes a terminal count.
// Ports: clk, rst (sync, high), clear, tick in; done out (combinational).
module period_tick_counter
  import motor_ctrl_pkg::*;
#(
  parameter int unsigned TERM = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TERM - 1);

  logic [CNT_W-1:0] count;

  assign done = tick && (count == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear)
      count <= '0;
    else if (done)
      count <= '0;
    else if (tick)
      count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/motor_speed_sequencer.sv
// Soft-start/soft-stop ramp controller for the PWM motor driver.
// Ports: clk, rst, period_tick, req_valid/req_speed/req_ready, estop in;
// psw, motor_en, at_target, busy out (registered), req_ready from state.
module motor_speed_sequencer
  import motor_ctrl_pkg::*;
#(
  parameter int unsigned STEP_PERIODS = 4,
  parameter int unsigned ESTOP_HOLD   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               period_tick,
  input  logic               req_valid,
  input  logic [LEVEL_W-1:0] req_speed,
  output logic               req_ready,
  input  logic               estop,
  output logic [PSW_W-1:0]   psw,
  output logic               motor_en,
  output logic               at_target,
  output logic               busy
);

  motor_seq_state_t state;
  motor_seq_state_t state_n;

  logic [LEVEL_W-1:0] level;
  logic [LEVEL_W-1:0] level_n;
  logic [LEVEL_W-1:0] target;
  logic [LEVEL_W-1:0] target_n;

  logic accept;
  logic ramping;
  logic going_up;
  logic step_done;
  logic hold_tick;
  logic hold_clear;
  logic hold_done;

  assign req_ready = (state != S_ESTOP) &&
                     (state != S_COOLDOWN);

  // Estop wins over a request presented in the same cycle.
  assign accept = req_valid && req_ready && !estop;

  // Step pacing only runs while a ramp still has distance to cover;
  // a retarget keeps the partial count.
  assign ramping = ((state == S_RAMP_UP) ||
                    (state == S_RAMP_DOWN)) &&
                   (level != target) && !estop;

  assign going_up = (target > level);

  assign hold_tick  = period_tick && !estop &&
                      (state == S_COOLDOWN);
  assign hold_clear = estop || (state != S_COOLDOWN);

  period_tick_counter #(
    .TERM (STEP_PERIODS)
  ) u_step_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (!ramping),
    .tick  (period_tick && ramping),
    .done  (step_done)
  );

  period_tick_counter #(
    .TERM (ESTOP_HOLD)
  ) u_hold_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (hold_clear),
    .tick  (hold_tick),
    .done  (hold_done)
  );

  always_comb begin
    state_n  = state;
    level_n  = level;
    target_n = target;
    if (estop) begin
      state_n  = S_ESTOP;
      level_n  = '0;
      target_n = '0;
    end else begin
      if (accept)
        target_n = sat_level(req_speed);
      unique case (state)
        S_IDLE, S_HOLD: begin
          if (target > level)
            state_n = S_RAMP_UP;
          else if (target < level)
            state_n = S_RAMP_DOWN;
          else if (level == '0)
            state_n = S_IDLE;
        end
        S_RAMP_UP, S_RAMP_DOWN: begin
          if (level == target) begin
            state_n = S_HOLD;
          end else begin
            // Direction follows the registered target, so a
            // step on the accept cycle still heads for the old one.
            state_n = going_up ? S_RAMP_UP : S_RAMP_DOWN;
            if (step_done) begin
              if (going_up) begin
                if (level != LEVEL_W'(MAX_LEVEL))
                  level_n = level + LEVEL_W'(1);
              end else begin
                if (level != '0)
                  level_n = level - LEVEL_W'(1);
              end
            end
          end
        end
        S_ESTOP: begin
          state_n = S_COOLDOWN;
        end
        S_COOLDOWN: begin
          if (hold_done)
            state_n = S_IDLE;
        end
        default: begin
          state_n = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      level     <= '0;
      target    <= '0;
      psw       <= '0;
      motor_en  <= 1'b0;
      at_target <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      level     <= level_n;
      target    <= target_n;
      psw       <= level_to_psw(level_n);
      motor_en  <= (level_n != '0);
      at_target <= (level_n == target_n) &&
                   (state_n != S_ESTOP) &&
                   (state_n != S_COOLDOWN);
      busy      <= (state_n == S_RAMP_UP) ||
                   (state_n == S_RAMP_DOWN);
    end
  end

endmodule
